// File: rtl/timeout_counter_bank.sv
// ---------------------------------------------------------------------------
// timeout_counter_bank
//
// Bank of CHANNELS independent timeout up-counters. Each channel latches its
// own limit and mode on start, counts while running, and signals expiry with
// a one-cycle tick plus a sticky overflow flag. One-shot channels park in
// DONE after expiry. Periodic channels reload to zero and keep running.
//
// Optional feature (macro TIMEOUT_BANK_EXPIRE_CNT_EN):
//   Adds o_EXP_CNT, an 8-bit saturating expiry counter per channel. The
//   counter clears on i_CLEAR, on i_START, or on reset.
//
// Parameters:
//   COUNTER_BITS  width of each channel counter and limit
//   CHANNELS      number of channels (1..16)
//
// Ports:
//   i_CLK           clock, rising edge
//   i_RST           asynchronous active-high reset
//   i_LIM           per-channel limit; channel k uses [k*COUNTER_BITS +: COUNTER_BITS]
//   i_MODE          per-channel mode, sampled with i_START (0 one-shot, 1 periodic)
//   i_START         per-channel start/restart strobe
//   i_CLEAR         per-channel synchronous clear to IDLE
//   i_PAUSE         per-channel pause level
//   o_BUSY          channel is in RUN or PAUSED
//   o_TICK          one-cycle pulse on each expiry
//   o_OVERFLOW      sticky expiry flag
//   o_ANY_OVERFLOW  combinational OR of o_OVERFLOW
//   o_EXP_CNT       per-channel expiry count (only with the macro defined)
// ---------------------------------------------------------------------------
module timeout_counter_bank #(
  parameter int COUNTER_BITS = 32,
  parameter int CHANNELS     = 4
) (
  input  logic                             i_CLK,
  input  logic                             i_RST,
  input  logic [CHANNELS*COUNTER_BITS-1:0] i_LIM,
  input  logic [CHANNELS-1:0]              i_MODE,
  input  logic [CHANNELS-1:0]              i_START,
  input  logic [CHANNELS-1:0]              i_CLEAR,
  input  logic [CHANNELS-1:0]              i_PAUSE,
  output logic [CHANNELS-1:0]              o_BUSY,
  output logic [CHANNELS-1:0]              o_TICK,
  output logic [CHANNELS-1:0]              o_OVERFLOW,
`ifdef TIMEOUT_BANK_EXPIRE_CNT_EN
  output logic [CHANNELS*8-1:0]            o_EXP_CNT,
`endif
  output logic                             o_ANY_OVERFLOW
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic [COUNTER_BITS-1:0] COUNT_ONE  = {{(COUNTER_BITS-1){1'b0}}, 1'b1};
  localparam logic [COUNTER_BITS-1:0] COUNT_ZERO = '0;

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
      state_t                  state_reg;
      logic [COUNTER_BITS-1:0] count_reg;
      logic [COUNTER_BITS-1:0] limit_reg;
      logic                    mode_reg;
      logic                    busy_reg;
      logic                    tick_reg;
      logic                    ovf_reg;
      logic                    expire;

      // Expiry only happens on a genuine counting edge: running, not being
      // paused, and not overridden by a clear or start on the same edge.
      assign expire = (state_reg == ST_RUN) && !i_PAUSE[gi] &&
                      !i_CLEAR[gi] && !i_START[gi] && (count_reg == limit_reg);

      always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
          state_reg <= ST_IDLE;
          count_reg <= COUNT_ZERO;
          limit_reg <= COUNT_ZERO;
          mode_reg  <= 1'b0;
          busy_reg  <= 1'b0;
          tick_reg  <= 1'b0;
          ovf_reg   <= 1'b0;
        end else if (i_CLEAR[gi]) begin
          state_reg <= ST_IDLE;
          count_reg <= COUNT_ZERO;
          busy_reg  <= 1'b0;
          tick_reg  <= 1'b0;
          ovf_reg   <= 1'b0;
        end else if (i_START[gi]) begin
          // A restart discards progress, including an expiry due this edge.
          state_reg <= ST_RUN;
          count_reg <= COUNT_ZERO;
          limit_reg <= i_LIM[gi*COUNTER_BITS +: COUNTER_BITS];
          mode_reg  <= i_MODE[gi];
          busy_reg  <= 1'b1;
          tick_reg  <= 1'b0;
          ovf_reg   <= 1'b0;
        end else begin
          tick_reg <= 1'b0;
          unique case (state_reg)
            ST_RUN: begin
              if (i_PAUSE[gi]) begin
                state_reg <= ST_PAUSED;
              end else if (expire) begin
                tick_reg <= 1'b1;
                ovf_reg  <= 1'b1;
                if (mode_reg) begin
                  count_reg <= COUNT_ZERO;
                end else begin
                  // count_reg already equals the limit, so it simply holds.
                  state_reg <= ST_DONE;
                  busy_reg  <= 1'b0;
                end
              end else begin
                count_reg <= count_reg + COUNT_ONE;
              end
            end
            ST_PAUSED: begin
              // Leaving pause costs one edge with no counting.
              if (!i_PAUSE[gi]) begin
                state_reg <= ST_RUN;
              end
            end
            default: begin
              // IDLE and DONE hold everything until start or clear.
            end
          endcase
        end
      end

      assign o_BUSY[gi]     = busy_reg;
      assign o_TICK[gi]     = tick_reg;
      assign o_OVERFLOW[gi] = ovf_reg;

`ifdef TIMEOUT_BANK_EXPIRE_CNT_EN
      logic [7:0] exp_cnt_reg;

      always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
          exp_cnt_reg <= 8'd0;
        end else if (i_CLEAR[gi] || i_START[gi]) begin
          exp_cnt_reg <= 8'd0;
        end else if (expire && (exp_cnt_reg != 8'hFF)) begin
          exp_cnt_reg <= exp_cnt_reg + 8'd1;
        end
      end

      assign o_EXP_CNT[gi*8 +: 8] = exp_cnt_reg;
`endif
    end
  endgenerate

  assign o_ANY_OVERFLOW = |o_OVERFLOW;

endmodule

// File: tb/tb_timeout_counter_bank.sv
// ---------------------------------------------------------------------------
// tb_timeout_counter_bank
//
// Directed test of timeout_counter_bank with CHANNELS=4, COUNTER_BITS=32.
// Inputs change 1 time unit after a rising edge; outputs are sampled at the
// same point, so each check sees the result of the edge just taken.
// ---------------------------------------------------------------------------
module tb_timeout_counter_bank;

  localparam int CB = 32;
  localparam int CH = 4;

  logic               clk;
  logic               rst;
  logic [CH*CB-1:0]   lim;
  logic [CH-1:0]      mode;
  logic [CH-1:0]      start;
  logic [CH-1:0]      clear;
  logic [CH-1:0]      pause;
  logic [CH-1:0]      busy;
  logic [CH-1:0]      tick;
  logic [CH-1:0]      ovf;
  logic               any_ovf;
`ifdef TIMEOUT_BANK_EXPIRE_CNT_EN
  logic [CH*8-1:0]    exp_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  timeout_counter_bank #(
    .COUNTER_BITS (CB),
    .CHANNELS     (CH)
  ) dut (
    .i_CLK          (clk),
    .i_RST          (rst),
    .i_LIM          (lim),
    .i_MODE         (mode),
    .i_START        (start),
    .i_CLEAR        (clear),
    .i_PAUSE        (pause),
    .o_BUSY         (busy),
    .o_TICK         (tick),
    .o_OVERFLOW     (ovf),
`ifdef TIMEOUT_BANK_EXPIRE_CNT_EN
    .o_EXP_CNT      (exp_cnt),
`endif
    .o_ANY_OVERFLOW (any_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_all();
    clear = '1;
    cyc();
    clear = '0;
  endtask

  // Safety net so the run can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    int ticks;
    logic [CH-1:0] exp_vec;
    logic [CH-1:0] exp_ovf;

    rst   = 1'b1;
    lim   = '0;
    mode  = '0;
    start = '0;
    clear = '0;
    pause = '0;

    // ---------------- reset state
    #12;
    check("rst_busy", 64'(busy), 64'h0);
    check("rst_tick", 64'(tick), 64'h0);
    check("rst_ovf",  64'(ovf),  64'h0);
    check("rst_any",  64'(any_ovf), 64'h0);
    @(negedge clk);
    rst = 1'b0;
    cyc();
    $display("reset released");

    // ---------------- one-shot ch0, L=5: tick after edge N+6
    lim[0*CB +: CB] = 32'd5;
    mode[0] = 1'b0;
    start[0] = 1'b1;
    cyc();
    start[0] = 1'b0;
    check("os_busy_start", 64'(busy[0]), 64'h1);
    for (int k = 1; k <= 8; k++) begin
      cyc();
      check("os_tick", 64'(tick[0]), 64'(k == 6));
      check("os_ovf",  64'(ovf[0]),  64'(k >= 6));
      check("os_busy", 64'(busy[0]), 64'(k < 6));
      check("os_any",  64'(any_ovf), 64'(k >= 6));
    end
    $display("one-shot ch0 L=5 done");

    // ---------------- periodic ch1, L=3: tick every 4 cycles
    clear_all();
    lim[1*CB +: CB] = 32'd3;
    mode[1] = 1'b1;
    start[1] = 1'b1;
    cyc();
    start[1] = 1'b0;
    ticks = 0;
    for (int k = 1; k <= 20; k++) begin
      cyc();
      check("per_tick", 64'(tick[1]), 64'((k % 4) == 0));
      check("per_busy", 64'(busy[1]), 64'h1);
      ticks += int'(tick[1]);
    end
    check("per_tick_count", 64'(ticks), 64'd5);
`ifdef TIMEOUT_BANK_EXPIRE_CNT_EN
    check("per_exp_cnt", 64'(exp_cnt[1*8 +: 8]), 64'd5);
`endif
    $display("periodic ch1 L=3 ticks=%0d", ticks);

    // ---------------- ch2 L=10 with 4-cycle pause at count 3, limit changed mid-run
    clear_all();
    lim[2*CB +: CB] = 32'd10;
    mode[2] = 1'b0;
    start[2] = 1'b1;
    cyc();
    start[2] = 1'b0;
    lim[2*CB +: CB] = 32'd2;
    for (int k = 1; k <= 18; k++) begin
      pause[2] = (k >= 4) && (k <= 7);
      cyc();
      check("pause_tick", 64'(tick[2]), 64'(k == 16));
      check("pause_busy", 64'(busy[2]), 64'(k < 16));
    end
    pause[2] = 1'b0;
    $display("paused ch2 L=10 done");

    // ---------------- L=0 one-shot: tick on first edge after start
    clear_all();
    lim[0*CB +: CB] = 32'd0;
    mode[0] = 1'b0;
    start[0] = 1'b1;
    cyc();
    start[0] = 1'b0;
    check("l0_tick_start", 64'(tick[0]), 64'h0);
    cyc();
    check("l0_tick", 64'(tick[0]), 64'h1);
    check("l0_ovf",  64'(ovf[0]),  64'h1);
    check("l0_busy", 64'(busy[0]), 64'h0);
    $display("L=0 one-shot done");

    // ---------------- start on the expiry edge (L=2, expiry due at N+3)
    clear_all();
    lim[0*CB +: CB] = 32'd2;
    start[0] = 1'b1;
    cyc();
    start[0] = 1'b0;
    cyc();
    cyc();
    check("se_tick_pre", 64'(tick[0]), 64'h0);
    start[0] = 1'b1;
    cyc();
    start[0] = 1'b0;
    check("se_tick", 64'(tick[0]), 64'h0);
    check("se_ovf",  64'(ovf[0]),  64'h0);
    check("se_busy", 64'(busy[0]), 64'h1);
    for (int k = 1; k <= 3; k++) begin
      cyc();
      check("se_retick", 64'(tick[0]), 64'(k == 3));
    end
    $display("start on expiry done");

    // ---------------- clear and start together on ch3
    clear_all();
    lim[3*CB +: CB] = 32'd2;
    mode[3] = 1'b0;
    start[3] = 1'b1;
    cyc();
    start[3] = 1'b0;
    cyc();
    clear[3] = 1'b1;
    start[3] = 1'b1;
    cyc();
    clear[3] = 1'b0;
    start[3] = 1'b0;
    check("cs_busy", 64'(busy[3]), 64'h0);
    check("cs_tick", 64'(tick[3]), 64'h0);
    check("cs_ovf",  64'(ovf[3]),  64'h0);
    for (int k = 1; k <= 5; k++) begin
      cyc();
      check("cs_idle_ovf",  64'(ovf[3]),  64'h0);
      check("cs_idle_busy", 64'(busy[3]), 64'h0);
    end
    $display("clear+start ch3 done");

    // ---------------- asynchronous reset mid-run
    clear_all();
    lim[0*CB +: CB] = 32'd0;
    mode[0] = 1'b0;
    lim[1*CB +: CB] = 32'd1;
    mode[1] = 1'b1;
    start[1:0] = 2'b11;
    cyc();
    start = '0;
    cyc();
    cyc();
    check("ar_any_pre",  64'(any_ovf), 64'h1);
    check("ar_busy_pre", 64'(busy[1]), 64'h1);
    #3;
    rst = 1'b1;
    #1;
    check("ar_busy", 64'(busy), 64'h0);
    check("ar_tick", 64'(tick), 64'h0);
    check("ar_ovf",  64'(ovf),  64'h0);
    check("ar_any",  64'(any_ovf), 64'h0);
    rst = 1'b0;
    cyc();
    check("ar_busy_post", 64'(busy), 64'h0);
    $display("async reset mid-run done");

    // ---------------- all four channels, L=2,4,6,8
    clear_all();
    for (int i = 0; i < CH; i++) begin
      lim[i*CB +: CB] = 32'(2 + 2 * i);
    end
    mode = '0;
    start = '1;
    cyc();
    start = '0;
    for (int k = 1; k <= 10; k++) begin
      cyc();
      for (int i = 0; i < CH; i++) begin
        exp_vec[i] = (k == 2 * i + 3);
        exp_ovf[i] = (k >= 2 * i + 3);
      end
      check("all_tick", 64'(tick), 64'(exp_vec));
      check("all_ovf",  64'(ovf),  64'(exp_ovf));
      check("all_any",  64'(any_ovf), 64'(k >= 3));
    end
    $display("all channels done");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
